keypad_scan_fifo: RTL and testbench
===================================

// Module: keypad_scan_fifo
// PURPOSE
//  Parametrised keypad scanner, successor to the fixed 3x4 keypad driver.
//  - Drives the column lines one-hot and samples the row lines.
//  - Debounces press and release; encodes one key at a time.
//  - Queues key codes in a FIFO with a valid/ack handshake and raises INTR for the CPU.
//  - Sits between the keypad pins and the MCU I/O port and interrupt input.
// PARAMETERS
//  ROWS          4    number of row inputs (sensed)
//  COLS          3    number of column outputs (driven)
//  SCAN_DIV      1000 CLK cycles each column is held; must be >=2
//  DEBOUNCE_CYC  50000 consecutive stable cycles to accept a press or a release; must be >=1
//  FIFO_DEPTH    4    key-code queue entries; power of two, >=2
//  INTR_PULSE    0    0: INTR is a level (FIFO not empty); 1: INTR is a 1-cycle pulse per accepted push
// PORTS
//  CLK        in   1                           system clock
//  RST        in   1                           asynchronous reset, active-high
//  COL        out  COLS                        column drive, one-hot, active-high
//  ROW        in   ROWS                        row sense, active-high (external pull-downs); sync'd internally
//  KEY_CODE   out  CW=$clog2(ROWS*COLS)        FIFO head code = row*COLS+col
//  KEY_VALID  out  1                           FIFO not empty; KEY_CODE valid
//  KEY_ACK    in   1                           pop head when KEY_VALID=1
//  FIFO_COUNT out  $clog2(FIFO_DEPTH+1)        entries held
//  OVERFLOW   out  1                           sticky: a code was dropped because the FIFO was full
//  INTR       out  1                           interrupt request (see INTR_PULSE)
// BEHAVIOUR
//  Reset: COL=1 (col 0), KEY_CODE=0, KEY_VALID=0, FIFO_COUNT=0, OVERFLOW=0, INTR=0, FSM=SCAN, counters=0.
//  ROW passes through a 2-flop synchroniser; all decisions use the synced value (rs).
//  FSM states:
//   SCAN    - Hold COL for SCAN_DIV cycles, then sample rs on the last cycle.
//           - rs exactly one-hot: latch code = row*COLS+col; go to DEBOUNCE; COL stays frozen.
//           - rs==0 or rs multi-hot: advance COL; wrap COLS-1 -> 0.
//   DEBOUNCE - Count the cycles where rs equals the latched row pattern.
//           - Any mismatch: clear the count, advance COL, go to SCAN.
//           - Count reaches DEBOUNCE_CYC: issue a push request; go to HELD.
//   HELD    - Count the cycles where rs==0; any nonzero rs clears the count.
//           - Count reaches DEBOUNCE_CYC: advance COL; go to SCAN.
//           - No repeat codes while held.
//  FIFO (circular, head/tail pointers):
//   - Push accepted if not full, or if full and a pop occurs in the same cycle.
//   - A push otherwise rejected sets OVERFLOW; the new code is dropped and FIFO contents are unchanged.
//   - Pop occurs when KEY_ACK=1 and KEY_VALID=1; KEY_ACK while empty is ignored.
//   - Simultaneous push and pop: FIFO_COUNT is unchanged and KEY_CODE shows the next entry.
//   - Push into an empty FIFO: KEY_VALID=1 and KEY_CODE=code on the cycle after the push.
//   - KEY_CODE holds its last value when the FIFO is empty.
//  INTR: level = KEY_VALID (INTR_PULSE=0); registered one-cycle pulse on the cycle after each accepted push (INTR_PULSE=1).
//  OVERFLOW clears only on RST.
//  RST asserted mid-press or mid-debounce: the FSM, FIFO and flags return to their reset values immediately; no partial push.
//  Latency, press stable from cycle t: code visible <= t + 2 (sync) + COLS*SCAN_DIV + DEBOUNCE_CYC + 1.
// TESTING (ROWS=4 COLS=3 SCAN_DIV=4 DEBOUNCE_CYC=8 FIFO_DEPTH=4 unless noted)
//  1. Reset, no keys -> COL cycles 001,010,100,001 with each value held 4 CLK; KEY_VALID=0, INTR=0.
//  2. Hold row2 while col1 is driven for 40 cycles, then release -> exactly one push, KEY_CODE=7, KEY_VALID=1, INTR=1; release debounced, scan resumes at col2.
//  3. Bounce row0 high for 3 cycles, low for 1, repeatedly on col0 -> no push, FIFO_COUNT=0.
//  4. Press/release 5 keys with codes 0,1,2,3,4 and no ACK -> FIFO_COUNT=4, OVERFLOW=1, pops return 0,1,2,3 in order.
//  5. FIFO full, KEY_ACK on the same cycle as the 5th push -> FIFO_COUNT stays 4, OVERFLOW=0, code 4 is stored.
//  6. Rows 1 and 3 pressed together on col0 -> ignored, no push.
//  7. INTR_PULSE=1: two separate presses -> two 1-cycle INTR pulses.
//  8. RST asserted mid-DEBOUNCE -> all outputs return to their reset values; FIFO_COUNT=0.

Source files
------------

// File: rtl/keypad_scan_fifo.sv
// Column-scanning keypad with press/release debounce, feeding a
// key-code FIFO with valid/ack handshake and an interrupt request.
module keypad_scan_fifo #(
   parameter int ROWS         = 4,
   parameter int COLS         = 3,
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CYC = 50000,
   parameter int FIFO_DEPTH   = 4,
   parameter int INTR_PULSE   = 0,
   localparam int CW = $clog2(ROWS*COLS),
   localparam int NW = $clog2(FIFO_DEPTH+1)
) (
   input  logic            CLK,
   input  logic            RST,
   output logic [COLS-1:0] COL,
   input  logic [ROWS-1:0] ROW,
   output logic [CW-1:0]   KEY_CODE,
   output logic            KEY_VALID,
   input  logic            KEY_ACK,
   output logic [NW-1:0]   FIFO_COUNT,
   output logic            OVERFLOW,
   output logic            INTR
);

   localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int DW  = $clog2(SCAN_DIV);
   localparam int BW  = $clog2(DEBOUNCE_CYC+1);
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam logic [COLS-1:0] COL_ONE = COLS'(1);

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD
   } state_t;

   state_t          state, state_n;
   logic [ROWS-1:0] row_s1, rs;
   logic [ROWS-1:0] pat, pat_n;
   logic [CIW-1:0]  col_idx, col_idx_n, col_adv;
   logic [DW-1:0]   div_cnt, div_cnt_n;
   logic [BW-1:0]   deb_cnt, deb_cnt_n;
   logic [CW-1:0]   code_lat, code_lat_n, code_calc;
   logic            one_hot;
   logic            push_req;

   logic [CW-1:0]   mem [FIFO_DEPTH];
   logic [PW-1:0]   head, tail, head_nx;
   logic [NW-1:0]   count;
   logic [CW-1:0]   code_q;
   logic            ovf_q, intr_q;
   logic            full, pop, push_ok;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         row_s1 <= '0;
         rs     <= '0;
      end else begin
         row_s1 <= ROW;
         rs     <= row_s1;
      end
   end

   assign COL     = COL_ONE << col_idx;
   assign col_adv = (col_idx == CIW'(COLS-1)) ? '0 : col_idx + 1'b1;
   assign one_hot = (rs != '0) && ((rs & (rs - 1'b1)) == '0);

   always_comb begin
      code_calc = '0;
      for (int r = 0; r < ROWS; r++)
         if (rs[r]) code_calc = CW'(r*COLS + int'(col_idx));
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= SCAN;
         col_idx  <= '0;
         div_cnt  <= '0;
         deb_cnt  <= '0;
         code_lat <= '0;
         pat      <= '0;
      end else begin
         state    <= state_n;
         col_idx  <= col_idx_n;
         div_cnt  <= div_cnt_n;
         deb_cnt  <= deb_cnt_n;
         code_lat <= code_lat_n;
         pat      <= pat_n;
      end
   end

   always_comb begin
      state_n    = state;
      col_idx_n  = col_idx;
      div_cnt_n  = div_cnt;
      deb_cnt_n  = deb_cnt;
      code_lat_n = code_lat;
      pat_n      = pat;
      push_req   = 1'b0;
      unique case (state)
         SCAN: begin
            if (div_cnt == DW'(SCAN_DIV-1)) begin
               div_cnt_n = '0;
               deb_cnt_n = '0;
               if (one_hot) begin
                  pat_n      = rs;
                  code_lat_n = code_calc;
                  state_n    = DEBOUNCE;
               end else begin
                  col_idx_n = col_adv;
               end
            end else begin
               div_cnt_n = div_cnt + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (rs != pat) begin
               deb_cnt_n = '0;
               col_idx_n = col_adv;
               state_n   = SCAN;
            end else if (deb_cnt == BW'(DEBOUNCE_CYC-1)) begin
               deb_cnt_n = '0;
               push_req  = 1'b1;
               state_n   = HELD;
            end else begin
               deb_cnt_n = deb_cnt + 1'b1;
            end
         end
         HELD: begin
            if (rs != '0) begin
               deb_cnt_n = '0;
            end else if (deb_cnt == BW'(DEBOUNCE_CYC-1)) begin
               deb_cnt_n = '0;
               col_idx_n = col_adv;
               state_n   = SCAN;
            end else begin
               deb_cnt_n = deb_cnt + 1'b1;
            end
         end
         default: state_n = SCAN;
      endcase
   end

   assign KEY_VALID  = (count != '0);
   assign full       = (count == NW'(FIFO_DEPTH));
   assign pop        = KEY_ACK && KEY_VALID;
   assign push_ok    = push_req && (!full || pop);
   assign head_nx    = head + 1'b1;
   assign KEY_CODE   = code_q;
   assign FIFO_COUNT = count;
   assign OVERFLOW   = ovf_q;
   assign INTR       = (INTR_PULSE != 0) ? intr_q : KEY_VALID;

   always_ff @(posedge CLK)
      if (push_ok) mem[tail] <= code_lat;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         head   <= '0;
         tail   <= '0;
         count  <= '0;
         code_q <= '0;
         ovf_q  <= 1'b0;
         intr_q <= 1'b0;
      end else begin
         intr_q <= push_ok;
         if (push_req && full && !pop) ovf_q <= 1'b1;
         if (pop) head <= head_nx;
         if (push_ok) tail <= tail + 1'b1;
         if (push_ok && !pop) count <= count + 1'b1;
         else if (pop && !push_ok) count <= count - 1'b1;
         // head register mirrors the entry that will sit at the head next cycle
         if (pop && count > NW'(1)) code_q <= mem[head_nx];
         else if (push_ok && (count == '0 || pop)) code_q <= code_lat;
      end
   end

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo with a keypad matrix model
// driving ROW from the scanned COL lines.
module tb_keypad_scan_fifo;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            key_ack = 1'b0;
   logic [2:0]      col, col_p;
   logic [3:0]      row, row_p;
   logic [3:0]      key_code, key_code_p;
   logic            key_valid, key_valid_p;
   logic [2:0]      fifo_count, fifo_count_p;
   logic            overflow, overflow_p;
   logic            intr, intr_p;

   logic [3:0][2:0] keys = '0;
   logic            bounce_en = 1'b0;
   logic [1:0]      bph = '0;
   logic            mon_en = 1'b0;
   logic            intr_prev;
   int              hi_cnt, rise_cnt;
   int              tests = 0;
   int              fails = 0;

   always #5 clk = ~clk;

   always @(posedge clk) bph <= bph + 2'd1;

   always_comb begin
      row   = '0;
      row_p = '0;
      for (int r = 0; r < 4; r++) begin
         row[r]   = |(keys[r] & col);
         row_p[r] = |(keys[r] & col_p);
      end
      if (bounce_en && bph == 2'd3) begin
         row   = '0;
         row_p = '0;
      end
   end

   always @(negedge clk) begin
      if (!mon_en) begin
         hi_cnt    = 0;
         rise_cnt  = 0;
         intr_prev = 1'b0;
      end else begin
         if (intr_p) hi_cnt++;
         if (intr_p && !intr_prev) rise_cnt++;
         intr_prev = intr_p;
      end
   end

   keypad_scan_fifo #(
      .ROWS(4), .COLS(3), .SCAN_DIV(4), .DEBOUNCE_CYC(8),
      .FIFO_DEPTH(4), .INTR_PULSE(0)
   ) dut (
      .CLK(clk), .RST(rst), .COL(col), .ROW(row),
      .KEY_CODE(key_code), .KEY_VALID(key_valid),
      .KEY_ACK(key_ack), .FIFO_COUNT(fifo_count),
      .OVERFLOW(overflow), .INTR(intr)
   );

   keypad_scan_fifo #(
      .ROWS(4), .COLS(3), .SCAN_DIV(4), .DEBOUNCE_CYC(8),
      .FIFO_DEPTH(4), .INTR_PULSE(1)
   ) dut_p (
      .CLK(clk), .RST(rst), .COL(col_p), .ROW(row_p),
      .KEY_CODE(key_code_p), .KEY_VALID(key_valid_p),
      .KEY_ACK(key_ack), .FIFO_COUNT(fifo_count_p),
      .OVERFLOW(overflow_p), .INTR(intr_p)
   );

   task automatic do_reset();
      rst       = 1'b1;
      keys      = '0;
      bounce_en = 1'b0;
      key_ack   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic press(input int r, input int c);
      keys[r][c] = 1'b1;
      repeat (40) @(posedge clk);
      #1 keys[r][c] = 1'b0;
      repeat (20) @(posedge clk);
      #1;
   endtask

   task automatic pop_one();
      key_ack = 1'b1;
      @(posedge clk);
      #1 key_ack = 1'b0;
   endtask

   task automatic wait_col(input logic [2:0] v, input bit eq);
      int n = 0;
      while (((col === v) != eq) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      tests++;
      if (n >= 100) begin
         fails++;
         $display("FAIL wait_col: col=%b target=%b eq=%0d", col, v, eq);
      end
   endtask

   task automatic test_reset();
      logic [2:0] exp_col [4];
      exp_col[0] = 3'b001;
      exp_col[1] = 3'b010;
      exp_col[2] = 3'b100;
      exp_col[3] = 3'b001;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({col, key_code, key_valid, fifo_count, overflow, intr}
          !== {3'b001, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset_vals: col=%b code=%0d v=%b n=%0d o=%b i=%b",
                  col, key_code, key_valid, fifo_count, overflow, intr);
      end
      do_reset();
      for (int i = 0; i < 16; i++) begin
         tests++;
         if (col !== exp_col[i/4]) begin
            fails++;
            $display("FAIL scan_col[%0d]: got %b expected %b",
                     i, col, exp_col[i/4]);
         end
         @(posedge clk);
         #1;
      end
      tests++;
      if (key_valid !== 1'b0 || intr !== 1'b0) begin
         fails++;
         $display("FAIL idle_flags: valid=%b intr=%b expected 0 0",
                  key_valid, intr);
      end
   endtask

   task automatic test_single_press();
      do_reset();
      keys[2][1] = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      tests++;
      if ({fifo_count, key_code, key_valid, intr, overflow, col}
          !== {3'd1, 4'd7, 1'b1, 1'b1, 1'b0, 3'b010}) begin
         fails++;
         $display("FAIL press_held: n=%0d code=%0d v=%b i=%b o=%b col=%b",
                  fifo_count, key_code, key_valid, intr, overflow, col);
      end
      keys[2][1] = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      tests++;
      if (col !== 3'b100) begin
         fails++;
         $display("FAIL resume_col: got %b expected 100", col);
      end
      repeat (20) @(posedge clk);
      #1;
      tests++;
      if (fifo_count !== 3'd1 || key_code !== 4'd7) begin
         fails++;
         $display("FAIL one_push: n=%0d code=%0d expected 1 7",
                  fifo_count, key_code);
      end
   endtask

   task automatic test_bounce();
      do_reset();
      bounce_en  = 1'b1;
      keys[0][0] = 1'b1;
      repeat (200) @(posedge clk);
      #1;
      tests++;
      if (fifo_count !== 3'd0 || key_valid !== 1'b0) begin
         fails++;
         $display("FAIL bounce: n=%0d v=%b expected 0 0",
                  fifo_count, key_valid);
      end
      keys      = '0;
      bounce_en = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      press(0, 0);
      press(0, 1);
      press(0, 2);
      press(1, 0);
      press(1, 1);
      tests++;
      if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
         fails++;
         $display("FAIL ovf_state: n=%0d ovf=%b expected 4 1",
                  fifo_count, overflow);
      end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (key_code !== 4'(i) || key_valid !== 1'b1) begin
            fails++;
            $display("FAIL pop_order[%0d]: code=%0d v=%b expected %0d 1",
                     i, key_code, key_valid, i);
         end
         pop_one();
      end
      pop_one();
      tests++;
      if ({fifo_count, key_valid, key_code, overflow}
          !== {3'd0, 1'b0, 4'd3, 1'b1}) begin
         fails++;
         $display("FAIL empty_hold: n=%0d v=%b code=%0d o=%b exp 0 0 3 1",
                  fifo_count, key_valid, key_code, overflow);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      press(0, 0);
      press(0, 1);
      press(0, 2);
      press(1, 0);
      wait_col(3'b010, 1'b0);
      keys[1][1] = 1'b1;
      wait_col(3'b010, 1'b1);
      repeat (11) @(posedge clk);
      #1 key_ack = 1'b1;
      @(posedge clk);
      #1 key_ack = 1'b0;
      tests++;
      if ({fifo_count, overflow, key_code} !== {3'd4, 1'b0, 4'd1}) begin
         fails++;
         $display("FAIL push_pop: n=%0d o=%b code=%0d expected 4 0 1",
                  fifo_count, overflow, key_code);
      end
      keys[1][1] = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      for (int i = 1; i < 5; i++) begin
         tests++;
         if (key_code !== 4'(i)) begin
            fails++;
            $display("FAIL b2b_order[%0d]: got %0d expected %0d",
                     i, key_code, i);
         end
         pop_one();
      end
   endtask

   task automatic test_multi_key();
      do_reset();
      keys[1][0] = 1'b1;
      keys[3][0] = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      tests++;
      if (fifo_count !== 3'd0 || key_valid !== 1'b0) begin
         fails++;
         $display("FAIL multi_key: n=%0d v=%b expected 0 0",
                  fifo_count, key_valid);
      end
      wait_col(3'b100, 1'b1);
      keys = '0;
   endtask

   task automatic test_intr_pulse();
      do_reset();
      mon_en = 1'b1;
      press(0, 2);
      press(3, 0);
      tests++;
      if (hi_cnt !== 2 || rise_cnt !== 2) begin
         fails++;
         $display("FAIL intr_pulse: high=%0d rises=%0d expected 2 2",
                  hi_cnt, rise_cnt);
      end
      tests++;
      if (intr !== 1'b1 || intr_p !== 1'b0 || fifo_count_p !== 3'd2) begin
         fails++;
         $display("FAIL intr_mode: lvl=%b pulse=%b n=%0d expected 1 0 2",
                  intr, intr_p, fifo_count_p);
      end
      mon_en = 1'b0;
   endtask

   task automatic test_mid_reset();
      do_reset();
      press(2, 2);
      tests++;
      if (fifo_count !== 3'd1 || key_code !== 4'd8) begin
         fails++;
         $display("FAIL pre_rst: n=%0d code=%0d expected 1 8",
                  fifo_count, key_code);
      end
      wait_col(3'b010, 1'b0);
      keys[0][1] = 1'b1;
      wait_col(3'b010, 1'b1);
      repeat (6) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      tests++;
      if ({col, key_code, key_valid, fifo_count, overflow, intr}
          !== {3'b001, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL mid_rst: col=%b code=%0d v=%b n=%0d o=%b i=%b",
                  col, key_code, key_valid, fifo_count, overflow, intr);
      end
      keys = '0;
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      tests++;
      if (fifo_count !== 3'd0 || key_valid !== 1'b0) begin
         fails++;
         $display("FAIL no_partial: n=%0d v=%b expected 0 0",
                  fifo_count, key_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_overflow();
      test_back_to_back();
      test_multi_key();
      test_intr_pulse();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
